// File: rtl/imem_fetch_responder.sv
// Instruction fetch responder: one-line fetch buffer in front of instruction memory.
// Hits answer combinationally; misses stall the PC while the whole line is refilled in address order.
module imem_fetch_responder #(
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instru_addr,
    input  logic        flush,
    output logic [31:0] instruction,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             valid_q, valid_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TAG_W-1:0] base_tag_q, base_tag_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             discard_q, discard_d;
    logic [31:0]      buf_q [LINE_WORDS];
    logic             buf_we;

    logic [TAG_W-1:0] cur_tag;
    logic [IDX_W-1:0] cur_idx;
    logic             hit;
    logic             unused_addr_lsbs;

    assign cur_tag          = instru_addr[31:2+IDX_W];
    assign cur_idx          = instru_addr[2+IDX_W-1:2];
    assign unused_addr_lsbs = ^instru_addr[1:0];
    assign hit              = valid_q && (tag_q == cur_tag);

    assign stall       = !hit;
    assign instruction = hit ? buf_q[cur_idx] : 32'h0;

    // Memory-side outputs depend only on registered state, never on mem_ready.
    assign mem_req  = (state_q == S_FILL);
    assign mem_addr = (state_q == S_FILL) ? {base_tag_q, cnt_q, 2'b00} : 32'h0;

    assign buf_we = (state_q == S_FILL) && mem_ready;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        tag_d      = tag_q;
        base_tag_d = base_tag_q;
        cnt_d      = cnt_q;
        discard_d  = discard_q;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    valid_d = 1'b0;
                end else if (!hit) begin
                    state_d    = S_FILL;
                    base_tag_d = cur_tag;
                    valid_d    = 1'b0;
                    cnt_d      = '0;
                    discard_d  = 1'b0;
                end
            end
            S_FILL: begin
                if (flush) begin
                    discard_d = 1'b1;
                end
                if (mem_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        // A flush on the final beat still poisons the line.
                        tag_d   = base_tag_q;
                        valid_d = !(discard_q || flush);
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            valid_q    <= 1'b0;
            tag_q      <= '0;
            base_tag_q <= '0;
            cnt_q      <= '0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            base_tag_q <= base_tag_d;
            cnt_q      <= cnt_d;
            discard_q  <= discard_d;
        end
    end

    // Line data carries no reset; valid_q guards every read.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[cnt_q] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: directed scenarios plus random traffic against a line-level model.
module tb_imem_fetch_responder;

    localparam int LW   = 4;
    localparam int IDX  = $clog2(LW);
    localparam logic [31:0] K = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instru_addr;
    logic        flush;
    logic [31:0] instruction;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    // Line-level reference: valid line number, pending word addresses of an active burst.
    bit          m_valid;
    logic [31:0] m_line;
    logic [31:0] m_fill_line;
    bit          m_disc;
    logic [31:0] m_pend[$];

    logic        obs_stall;
    logic [31:0] obs_instr;
    logic [31:0] obs_maddr;

    imem_fetch_responder #(.LINE_WORDS(LW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .instru_addr(instru_addr),
        .flush(flush),
        .instruction(instruction),
        .stall(stall),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_ready ? (mem_addr ^ K) : 32'hDEADBEEF;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a >> (2 + IDX);
    endfunction

    function automatic void model_reset();
        m_valid = 1'b0;
        m_disc  = 1'b0;
        m_pend.delete();
    endfunction

    // One clock cycle: drive inputs, compare at negedge, advance the model to the next edge.
    task automatic step(input logic [31:0] a, input logic f, input logic r);
        bit exp_hit;
        instru_addr = a;
        flush       = f;
        mem_ready   = r;
        @(negedge clk);
        obs_stall = stall;
        obs_instr = instruction;
        obs_maddr = mem_addr;
        exp_hit = m_valid && (line_of(a) == m_line);
        check_eq("stall", {31'b0, stall}, {31'b0, !exp_hit});
        check_eq("instruction", instruction, exp_hit ? ({a[31:2], 2'b00} ^ K) : 32'h0);
        check_eq("mem_req", {31'b0, mem_req}, {31'b0, m_pend.size() != 0});
        if (m_pend.size() != 0) begin
            check_eq("mem_addr", mem_addr, m_pend[0]);
            if (f) m_disc = 1'b1;
            if (r) begin
                void'(m_pend.pop_front());
                if (m_pend.size() == 0) begin
                    m_line  = m_fill_line;
                    m_valid = !m_disc;
                end
            end
        end else if (f) begin
            m_valid = 1'b0;
        end else if (!exp_hit) begin
            m_valid     = 1'b0;
            m_disc      = 1'b0;
            m_fill_line = line_of(a);
            for (int i = 0; i < LW; i++) begin
                m_pend.push_back((m_fill_line << (2 + IDX)) + 32'(4 * i));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        rst_n       = 1'b0;
        instru_addr = 32'h100;
        flush       = 1'b0;
        mem_ready   = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_stall", {31'b0, stall}, 32'd1);
        check_eq("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check_eq("rst_instr", instruction, 32'h0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Miss right after reset, then the 0x100 line fills.
        step(32'h100, 1'b0, 1'b1);
        step(32'h100, 1'b0, 1'b1);
        check_eq("post_rst_fill_addr", obs_maddr, 32'h100);
        repeat (3) step(32'h100, 1'b0, 1'b1);
        step(32'h104, 1'b0, 1'b1);
        check_eq("post_rst_hit", {31'b0, obs_stall}, 32'd0);

        // Cold miss at 0x40.
        step(32'h40, 1'b0, 1'b1);
        for (int i = 0; i < LW; i++) begin
            step(32'h40, 1'b0, 1'b1);
            check_eq("cold_mem_addr", obs_maddr, 32'h40 + 32'(4 * i));
        end
        step(32'h40, 1'b0, 1'b1);
        check_eq("cold_stall", {31'b0, obs_stall}, 32'd0);
        check_eq("cold_instr", obs_instr, 32'hA5A5A5E5);

        // Sequential hits, then the next line misses and refills back-to-back.
        step(32'h44, 1'b0, 1'b1);
        step(32'h48, 1'b0, 1'b1);
        step(32'h4C, 1'b0, 1'b1);
        check_eq("seq_hit_4c", obs_instr, 32'h4C ^ K);
        step(32'h50, 1'b0, 1'b1);
        check_eq("seq_miss_50", {31'b0, obs_stall}, 32'd1);
        step(32'h50, 1'b0, 1'b1);
        check_eq("refill_50", obs_maddr, 32'h50);
        repeat (4) step(32'h50, 1'b0, 1'b1);

        // Wait states: ready alternates 0/1 starting with 0.
        step(32'h200, 1'b0, 1'b0);
        k = 0;
        do begin
            k++;
            step(32'h200, 1'b0, (k % 2) == 0);
        end while (obs_stall && k < 40);
        check_eq("wait_latency", 32'(k), 32'd9);
        for (int i = 1; i < LW; i++) step(32'h200 + 32'(4 * i), 1'b0, 1'b1);

        // Flush on the second word of a fill: burst completes, line stays invalid, refill follows.
        step(32'h80, 1'b0, 1'b1);
        step(32'h80, 1'b0, 1'b1);
        step(32'h80, 1'b1, 1'b1);
        step(32'h80, 1'b0, 1'b1);
        step(32'h80, 1'b0, 1'b1);
        check_eq("flush_burst_end", obs_maddr, 32'h8C);
        step(32'h80, 1'b0, 1'b1);
        check_eq("flush_fill_discarded", {31'b0, obs_stall}, 32'd1);
        step(32'h80, 1'b0, 1'b1);
        check_eq("flush_refill_addr", obs_maddr, 32'h80);
        repeat (4) step(32'h80, 1'b0, 1'b1);
        // Flush in IDLE on a valid line.
        step(32'h84, 1'b1, 1'b1);
        check_eq("idle_flush_hit", {31'b0, obs_stall}, 32'd0);
        step(32'h84, 1'b0, 1'b1);
        check_eq("idle_flush_miss", {31'b0, obs_stall}, 32'd1);
        repeat (5) step(32'h84, 1'b0, 1'b1);

        // Reset in the middle of a burst, on the third word.
        step(32'h300, 1'b0, 1'b1);
        step(32'h300, 1'b0, 1'b1);
        step(32'h300, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_mem_req", {31'b0, mem_req}, 32'd0);
        check_eq("midrst_mem_addr", mem_addr, 32'h0);
        check_eq("midrst_stall", {31'b0, stall}, 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(32'h300, 1'b0, 1'b1);
        step(32'h300, 1'b0, 1'b1);
        check_eq("midrst_refill_addr", obs_maddr, 32'h300);
        repeat (4) step(32'h308, 1'b0, 1'b1);

        // Random traffic over a few lines with random waits and occasional flushes.
        for (int i = 0; i < 600; i++) begin
            step(32'h1000 + ($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3)),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_fetch_responder.md
# imem_fetch_responder

Instruction-side responder for the program counter. It accepts the PC's `instru_addr` every cycle and returns the addressed instruction from a one-line fetch buffer. On a miss it drives `stall` so the PC holds, then refills the line from instruction memory with a word-at-a-time req/ready handshake. It sits between the PC and the instruction memory port and is the only source of the PC's `stall` input.

## Interface
- `LINE_WORDS`, default 4: words per buffer line; power of two, at least 2.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instru_addr`  in  32  byte address from the PC; bits [1:0] ignored.
- `flush`  in  1  invalidates the buffered line.
- `instruction`  out  32  fetched word; meaningful only while `stall`=0.
- `stall`  out  1  to the PC; high whenever the addressed word is not available this cycle.
- `mem_req`  out  1  memory word request.
- `mem_addr`  out  32  word-aligned address of the requested word.
- `mem_ready`  in  1  memory returns `mem_rdata` this cycle for the current `mem_addr`.
- `mem_rdata`  in  32  memory read data.

## Operation
- Buffer state: `LINE_WORDS` data words, a tag `TAG = instru_addr[31:2+log2(LINE_WORDS)]`, a `valid` bit, fill counter `cnt`, fill base register, discard flag.
- Hit condition: `valid && tag == TAG(instru_addr)`. The hit check is combinational.
  - On a hit: `stall`=0 and `instruction` = the buffer word at `instru_addr[2+log2(LINE_WORDS)-1:2]`.
  - Otherwise: `stall`=1 and `instruction`=0.
- FSM states:
  - IDLE: `mem_req`=0. A miss with `flush`=0 moves to FILL at the next edge. On that edge: latch base = `{instru_addr[31:2+log2(LINE_WORDS)], 0}`, clear `valid`, set `cnt`=0, clear discard.
  - FILL: `mem_req`=1 and `mem_addr` = base + 4·`cnt`. `mem_addr` is held stable until `mem_ready`.
    - Each cycle with `mem_ready`=1: write `mem_rdata` into word `cnt`, then `cnt`++.
    - If `mem_ready`=1 and `cnt`=`LINE_WORDS`-1: load the tag from base, set `valid` unless discard is set, and return to IDLE.
- The fill always runs in address order and never aborts mid-burst, so memory sees only complete line bursts.
- `flush`:
  - In IDLE: clears `valid` at the next edge; no fill starts that cycle.
  - In FILL: sets discard. The burst completes, but `valid` stays 0, so a fresh miss follows.
- If `instru_addr` changes during FILL (PC not honouring `stall`), the latched line still completes. The hit check then uses the current address.
- A back-to-back miss immediately after a fill completes re-enters FILL one cycle later, after one IDLE cycle.
- Reset (asynchronous, any state, including mid-burst):
  - State → IDLE; `valid`, `cnt` and discard cleared; `mem_req`=0; `mem_addr`=0.
  - Outputs settle to `stall`=1 and `instruction`=0 while `rst_n`=0.
  - Buffer data is not reset.

## Timing
- Hit: zero added latency. `instruction` is valid in the same cycle `instru_addr` is presented, so the PC advances at the next edge.
- Miss with `mem_ready` always 1, `LINE_WORDS`=4:
  - Cycle 0: miss detected, `stall`=1.
  - Cycles 1–4: FILL, one word per cycle.
  - The edge ending cycle 4 sets `valid`.
  - Cycle 5: hit, `stall`=0.
  - Miss penalty = `LINE_WORDS`+1 cycles, plus one cycle per `mem_ready`=0 wait cycle.
- `stall` is combinational from `instru_addr` and registered state. The PC samples it at the same edge.
- `mem_req` and `mem_addr` are registered or derived only from state, never from `mem_ready` in the same cycle.

## Test plan
- Reset: hold `rst_n`=0 with `instru_addr`=0x100 → `stall`=1, `mem_req`=0, `instruction`=0. Release; the next cycle enters FILL with `mem_addr`=0x100.
- Cold miss: `instru_addr`=0x40, `mem_ready`=1, memory returns word = address ^ 0xA5A5A5A5.
  - Required: `mem_addr` 0x40, 0x44, 0x48, 0x4C on cycles 1–4.
  - Required: cycle 5 `stall`=0, `instruction`=0xA5A5A5E5.
- Sequential hits: after the fill, step `instru_addr` 0x44 → 0x4C → `stall`=0 each cycle with correct data. Then 0x50 → `stall`=1 and a refill at 0x50.
- Wait states: `mem_ready` toggles 0/1 during a fill of 0x200 → `mem_addr` holds on 0-cycles, no word is skipped or duplicated, and `stall` falls 9 cycles after the miss.
- Flush: assert `flush` during the second word of a fill of 0x80 → the burst completes to 0x8C, `valid` stays 0, and a new fill of 0x80 starts. A flush in IDLE on a valid line → the next access to the same line misses.
- Reset mid-fill: drop `rst_n` on the third word → `mem_req` falls immediately. After release, the same address refills from word 0.
